fir_avg_out_buf: RTL

- Output stage directly downstream of the 4-tap FIR moving-sum block.
- Consumes the FIR's registered (w+2)-bit sum each sample and divides it by 4, with selectable rounding, to form a w-bit moving average.
- Discards the start-up samples, where the window is not yet filled with real data.
- Buffers results in a small FIFO behind a valid/ready handshake to the consumer, since the FIR cannot stall.

---
 rtl/fir_avg_out_buf_pkg.sv | 12 +
 rtl/fir_avg_out_buf_if.sv | 28 ++
 rtl/fir_avg_out_buf_fifo.sv | 60 ++++++
 rtl/fir_avg_out_buf.sv | 106 ++++++++++
 4 files changed

// File: rtl/fir_avg_out_buf_pkg.sv
// rtl/fir_avg_out_buf_pkg.sv - shared constants and types for the FIR averaging output buffer
package fir_out_pkg;

  localparam int AVG_W     = 16;
  localparam int TAPS      = 4;
  localparam int AVG_SHIFT = 2;
  localparam int DROP_W    = 8;

  typedef logic [AVG_W+1:0] sum_t;
  typedef logic [AVG_W-1:0] avg_t;

endpackage

// File: rtl/fir_avg_out_buf_if.sv
// rtl/fir_avg_out_buf_if.sv - sample-in / average-out handshake bundle
interface fir_avg_out_buf_if #(
  parameter int w = 16
);

  logic [w+1:0] in_sum;
  logic         in_valid;
  logic [w-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_sum,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_sum,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/fir_avg_out_buf_fifo.sv
// rtl/fir_avg_out_buf_fifo.sv - power-of-two synchronous FIFO with head-entry read port
module fir_sync_fifo #(
  parameter int width = 16,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           wdata,
  output logic [width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth+1)-1:0] count
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = $clog2(depth + 1);

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;
  logic             push_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CNT_W'(depth)) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(depth));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fir_avg_out_buf.sv
// rtl/fir_avg_out_buf.sv - divides the FIR moving sum by four, skips warm-up and buffers results
module fir_avg_out_buf
  import fir_out_pkg::*;
#(
  parameter int w      = 16,
  parameter int DEPTH  = 4,
  parameter int WARMUP = TAPS + 1,
  parameter int ROUND  = 1
) (
  input  logic              clk,
  input  logic              reset,
  fir_avg_out_buf_if.slave  bus,
  input  logic              clear_ovf,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              warm
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WARM_W = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
  localparam logic [w+2:0] RND_ADD = (ROUND != 0) ? (w+3)'(2) : '0;

  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              warm_q, warm_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [w+2:0]      sum_ext;
  logic [w-1:0]      avg;
  logic              push_req;
  logic              pop_req;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [w-1:0]      fifo_rdata;

  // The widened sum cannot carry out: 4*(2^w-1)+2 still fits in w+2 bits.
  assign sum_ext = {1'b0, bus.in_sum} + RND_ADD;
  assign avg     = w'(sum_ext >> AVG_SHIFT);

  assign push_req = bus.in_valid && warm_q;
  assign pop_req  = bus.out_ready && (fifo_count != '0);
  assign drop     = push_req && fifo_full && !pop_req;

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    warm_d     = warm_q;
    if (bus.in_valid && !warm_q) begin
      warm_cnt_d = warm_cnt_q + 1'b1;
      if (warm_cnt_q == WARM_W'(WARMUP - 1)) begin
        warm_d = 1'b1;
      end
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != {DROP_W{1'b1}}) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt_q <= '0;
      warm_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      warm_q     <= warm_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  fir_sync_fifo #(
    .width (w),
    .depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (avg),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_data  = fifo_rdata;
  assign bus.out_valid = !fifo_empty;
  assign overflow      = ovf_q;
  assign drop_cnt      = drop_q;
  assign warm          = warm_q;

endmodule
